// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives enable/load/config; the slave returns the divided outputs.
interface clock_divider_prog_if #(
  parameter int CNT_W = 25
);
  logic             enable;
  logic             load;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             cfg_err;

  modport master (
    output enable, load, period, high_time,
    input  clk_out, tick, count, cfg_err
  );

  modport slave (
    input  enable, load, period, high_time,
    output clk_out, tick, count, cfg_err
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Programmable enable-gated clock divider: registered square wave plus a one-cycle tick.
// A new period/high time is staged in shadow registers and only takes effect at a wrap.
module clock_divider_prog #(
  parameter int CNT_W      = 25,
  parameter int DIV_RESET  = 500000,
  parameter int HIGH_RESET = 250000
) (
  input  logic                clk,
  input  logic                reset,
  clock_divider_prog_if.slave bus
);
  localparam logic [CNT_W-1:0] DIV_R  = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] HIGH_R = CNT_W'(HIGH_RESET);

  logic [CNT_W-1:0] count_q, count_nxt;
  logic [CNT_W-1:0] period_a, high_a, high_nxt;
  logic [CNT_W-1:0] period_s, high_s;
  logic             pending, clk_out_q, tick_q, cfg_err_q;
  logic             wrap, cfg_ok, apply;

  always_comb begin
    wrap      = (count_q == period_a - CNT_W'(1));
    cfg_ok    = (bus.period >= CNT_W'(2)) && (bus.high_time != '0) &&
                (bus.high_time < bus.period);
    // Only a config already pending before this edge may be applied at this wrap.
    apply     = bus.enable && wrap && pending;
    count_nxt = wrap ? '0 : count_q + CNT_W'(1);
    high_nxt  = apply ? high_s : high_a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      period_a  <= DIV_R;
      high_a    <= HIGH_R;
      period_s  <= DIV_R;
      high_s    <= HIGH_R;
      pending   <= 1'b0;
    end else begin
      tick_q    <= bus.enable && wrap;
      cfg_err_q <= bus.load && !cfg_ok;
      if (bus.enable) begin
        count_q   <= count_nxt;
        clk_out_q <= (count_nxt < high_nxt);
        if (apply) begin
          period_a <= period_s;
          high_a   <= high_s;
        end
      end
      if (bus.load && cfg_ok) begin
        period_s <= bus.period;
        high_s   <= bus.high_time;
        pending  <= 1'b1;
      end else if (apply) begin
        pending  <= 1'b0;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.cfg_err = cfg_err_q;
endmodule
